// File: rtl/node_io_q_pkg.sv
// rtl/node_io_q_pkg.sv - control constants, status indices and message field helpers for node_io_q
package node_io_pkg;

    localparam logic [2:0] CTRL_SEND   = 3'b100;
    localparam logic [2:0] CTRL_RECV   = 3'b010;
    localparam logic [2:0] CTRL_BYPASS = 3'b001;
    localparam logic [2:0] CTRL_IDLE   = 3'b000;

    localparam int STAT_RX_DROP  = 0;
    localparam int STAT_TX_DROP  = 1;
    localparam int STAT_CTRL_ERR = 2;

    // Helpers take messages zero-extended to this width so one function serves every MSG_W.
    localparam int MAX_MSG_W = 64;

    typedef enum logic [1:0] {
        OP_IDLE,
        OP_SEND,
        OP_RECV,
        OP_BYPASS
    } op_e;

    function automatic op_e decode_ctrl(input logic [2:0] ctrl);
        case (ctrl)
            CTRL_SEND:   return OP_SEND;
            CTRL_RECV:   return OP_RECV;
            CTRL_BYPASS: return OP_BYPASS;
            default:     return OP_IDLE;
        endcase
    endfunction

    function automatic logic ctrl_is_legal(input logic [2:0] ctrl);
        return $countones(ctrl) <= 1;
    endfunction

    function automatic logic msg_valid(input logic [MAX_MSG_W-1:0] msg, input int msg_w);
        logic [MAX_MSG_W-1:0] sh;
        sh = msg >> (msg_w - 1);
        return sh[0];
    endfunction

    function automatic logic [MAX_MSG_W-1:0] msg_dest(input logic [MAX_MSG_W-1:0] msg,
                                                      input int payload_w, input int dest_w);
        logic [MAX_MSG_W-1:0] mask;
        mask = (MAX_MSG_W'(1) << dest_w) - MAX_MSG_W'(1);
        return (msg >> payload_w) & mask;
    endfunction

    function automatic logic [MAX_MSG_W-1:0] msg_payload(input logic [MAX_MSG_W-1:0] msg,
                                                         input int payload_w);
        logic [MAX_MSG_W-1:0] mask;
        mask = (MAX_MSG_W'(1) << payload_w) - MAX_MSG_W'(1);
        return msg & mask;
    endfunction

endpackage

// File: rtl/node_io_q_if.sv
// rtl/node_io_q_if.sv - bus tap, injection, delivery and status signals of one node_io_q instance
interface node_io_q_if #(
    parameter int NUM_NODES = 8,
    parameter int PAYLOAD_W = 16,
    parameter int TXQ_DEPTH = 4,
    parameter int RXQ_DEPTH = 4
);
    localparam int DEST_W = $clog2(NUM_NODES);
    localparam int MSG_W  = 1 + DEST_W + PAYLOAD_W;

    logic [2:0]                   control_in;
    logic [MSG_W-1:0]             msg_in;
    logic [MSG_W-1:0]             inj_msg;
    logic                         inj_valid;
    logic                         inj_ready;
    logic [MSG_W-1:0]             msg_out;
    logic [DEST_W:0]              request_out;
    logic [PAYLOAD_W-1:0]         rx_data;
    logic                         rx_valid;
    logic                         rx_ready;
    logic [$clog2(TXQ_DEPTH):0]   tx_count;
    logic [$clog2(RXQ_DEPTH):0]   rx_count;
    logic [2:0]                   status;

    modport slave (
        input  control_in, msg_in, inj_msg, inj_valid, rx_ready,
        output inj_ready, msg_out, request_out, rx_data, rx_valid, tx_count, rx_count, status
    );

    modport master (
        output control_in, msg_in, inj_msg, inj_valid, rx_ready,
        input  inj_ready, msg_out, request_out, rx_data, rx_valid, tx_count, rx_count, status
    );
endinterface

// File: rtl/node_io_q_fifo.sv
// rtl/node_io_q_fifo.sv - msg_fifo: power-of-two circular queue with occupancy count
module msg_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    // Full/empty come from registered occupancy, so a same-cycle pop never makes room for a push.
    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign w_push_ok = i_push & ~o_full;
    assign w_pop_ok  = i_pop & ~o_empty;
    assign o_head    = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CW'(w_push_ok) - CW'(w_pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= i_push_data;
    end
endmodule

// File: rtl/node_io_q.sv
// rtl/node_io_q.sv - queued bus node: control decode, TX push arbitration, msg_out register, sticky status
module node_io_q
    import node_io_pkg::*;
#(
    parameter int NODE_NUMBER = 0,
    parameter int NUM_NODES   = 8,
    parameter int PAYLOAD_W   = 16,
    parameter int TXQ_DEPTH   = 4,
    parameter int RXQ_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    node_io_q_if.slave  bus
);
    localparam int DEST_W = $clog2(NUM_NODES);
    localparam int MSG_W  = 1 + DEST_W + PAYLOAD_W;
    localparam int TXC_W  = $clog2(TXQ_DEPTH) + 1;
    localparam int RXC_W  = $clog2(RXQ_DEPTH) + 1;
    localparam logic [DEST_W-1:0] NODE_ADDR = DEST_W'(NODE_NUMBER);

    op_e                    w_op;
    logic                   w_ctrl_err;
    logic                   w_in_valid;
    logic [DEST_W-1:0]      w_in_dest;
    logic [PAYLOAD_W-1:0]   w_in_payload;
    logic                   w_deliver;
    logic                   w_forward;
    logic                   w_inj_ready;
    logic                   w_tx_push;
    logic [MSG_W-1:0]       w_tx_push_data;
    logic                   w_tx_pop;
    logic [MSG_W-1:0]       w_tx_head;
    logic [DEST_W-1:0]      w_tx_dest;
    logic                   w_tx_full;
    logic                   w_tx_empty;
    logic [TXC_W-1:0]       w_tx_count;
    logic [PAYLOAD_W-1:0]   w_rx_head;
    logic                   w_rx_full;
    logic                   w_rx_empty;
    logic [RXC_W-1:0]       w_rx_count;
    logic [MSG_W-1:0]       w_msg_out_nxt;
    logic [2:0]             w_status_set;
    logic [MSG_W-1:0]       r_msg_out;
    logic [2:0]             r_status;

    assign w_op         = decode_ctrl(bus.control_in);
    assign w_ctrl_err   = ~ctrl_is_legal(bus.control_in);
    assign w_in_valid   = msg_valid(MAX_MSG_W'(bus.msg_in), MSG_W);
    assign w_in_dest    = DEST_W'(msg_dest(MAX_MSG_W'(bus.msg_in), PAYLOAD_W, DEST_W));
    assign w_in_payload = PAYLOAD_W'(msg_payload(MAX_MSG_W'(bus.msg_in), PAYLOAD_W));

    assign w_deliver = (w_op == OP_RECV) && w_in_valid && (w_in_dest == NODE_ADDR);
    assign w_forward = (w_op == OP_RECV) && w_in_valid && (w_in_dest != NODE_ADDR);

    // Forwarded traffic owns the single TX write port; local injection waits a cycle.
    assign w_inj_ready    = ~w_tx_full & ~w_forward;
    assign w_tx_push      = w_forward | (bus.inj_valid & w_inj_ready);
    assign w_tx_push_data = w_forward ? bus.msg_in : {1'b1, bus.inj_msg[MSG_W-2:0]};
    assign w_tx_pop       = (w_op == OP_SEND) & ~w_tx_empty;

    msg_fifo #(
        .WIDTH (MSG_W),
        .DEPTH (TXQ_DEPTH)
    ) u_tx_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_tx_push),
        .i_push_data (w_tx_push_data),
        .i_pop       (w_tx_pop),
        .o_head      (w_tx_head),
        .o_full      (w_tx_full),
        .o_empty     (w_tx_empty),
        .o_count     (w_tx_count)
    );

    msg_fifo #(
        .WIDTH (PAYLOAD_W),
        .DEPTH (RXQ_DEPTH)
    ) u_rx_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_deliver),
        .i_push_data (w_in_payload),
        .i_pop       (bus.rx_ready),
        .o_head      (w_rx_head),
        .o_full      (w_rx_full),
        .o_empty     (w_rx_empty),
        .o_count     (w_rx_count)
    );

    always_comb begin
        w_msg_out_nxt = '0;
        case (w_op)
            OP_SEND:   if (!w_tx_empty) w_msg_out_nxt = w_tx_head;
            OP_BYPASS: w_msg_out_nxt = bus.msg_in;
            default:   w_msg_out_nxt = '0;
        endcase
    end

    always_comb begin
        w_status_set                = '0;
        w_status_set[STAT_CTRL_ERR] = w_ctrl_err;
        w_status_set[STAT_TX_DROP]  = w_forward & w_tx_full;
        w_status_set[STAT_RX_DROP]  = w_deliver & w_rx_full;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_msg_out <= '0;
            r_status  <= '0;
        end else begin
            r_msg_out <= w_msg_out_nxt;
            r_status  <= r_status | w_status_set;
        end
    end

    assign w_tx_dest       = DEST_W'(msg_dest(MAX_MSG_W'(w_tx_head), PAYLOAD_W, DEST_W));
    assign bus.inj_ready   = w_inj_ready;
    assign bus.msg_out     = r_msg_out;
    assign bus.request_out = w_tx_empty ? '0 : {1'b1, w_tx_dest};
    assign bus.rx_data     = w_rx_head;
    assign bus.rx_valid    = ~w_rx_empty;
    assign bus.tx_count    = w_tx_count;
    assign bus.rx_count    = w_rx_count;
    assign bus.status      = r_status;
endmodule
